mem_stage_dm: RTL and testbench
===============================

Name: mem_stage_dm

Overview:
- MEM-stage data memory of the P7 pipelined MIPS core. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs sized loads and stores (lw/lh/lhu/lb/lbu, sw/sh/sb) on a word-organised RAM.
- Detects address exceptions and reports them to CP0.
- Cancels stores when the pipeline is flushed.
- Registers a write trace for the verification log.
- Load data is produced combinationally and is captured as DR_W by the downstream stage register.

Parameters:
- DEPTH, 4096, number of 32-bit words; the valid byte range is 0 to DEPTH*4-1.
- AW, 12, word-index width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock; all writes occur on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_m  in  32  PC of the instruction in MEM.
- addr  in  32  byte address (ALU output, AO_M).
- wdata  in  32  store data (already forwarded).
- re  in  1  load instruction in MEM.
- we  in  1  store instruction in MEM.
- mem_op  in  3  access size: 000 word; 001 half unsigned; 010 half signed; 011 byte unsigned; 100 byte signed; 101-111 reserved.
- flush  in  1  interrupt or exception taken this cycle; cancels the store.
- rdata  out  32  extended load data (combinational).
- exc_valid  out  1  address exception present (combinational).
- exc_code  out  5  4 = AdEL, 5 = AdES, 0 = none.
- dbg_we  out  1  registered: a write committed on the previous edge.
- dbg_pc  out  32  registered PC of that write.
- dbg_addr  out  32  registered word-aligned byte address of that write.
- dbg_data  out  32  registered full merged word written.

Behaviour:
- Word index = addr[AW+1:2]. Byte offset = addr[1:0].
- Misaligned access:
  - word access with addr[1:0] != 0;
  - half access with addr[0] != 0;
  - any reserved mem_op.
- Out of range: addr >= DEPTH*4. This test uses the full 32-bit compare; no aliasing.
- we=1 and re=1 together: treated as a store only; re is ignored.
- Exception decode (combinational):
  - we & (misaligned | out of range) -> exc_valid=1, exc_code=5.
  - else re & (misaligned | out of range) -> exc_valid=1, exc_code=4.
  - otherwise exc_valid=0, exc_code=0.
- Load path (combinational):
  - Word: rdata = mem[idx].
  - Half: select mem[idx][15:0] when addr[1]=0, else [31:16]; zero-extend (001) or sign-extend (010).
  - Byte: select lane addr[1:0]; lane 0 = bits [7:0], little-endian; zero-extend (011) or sign-extend (100).
  - When re=0, or on a load exception: rdata = 0.
- Store commit condition, evaluated at the rising clk edge: we & ~exc_valid & ~flush & ~reset.
  - Word: whole word replaced.
  - Half: only the selected 16-bit lane is written.
  - Byte: only the selected 8-bit lane is written.
  - Other lanes keep their previous value (read-modify-write within one cycle; no extra latency).
- Store is blocked when the commit condition is false: no memory change, and dbg_we=0 on the next cycle.
- A load in the cycle after a store to the same word returns the updated value. A same-cycle load cannot occur, because a store and a load are never both active.
- Debug registers:
  - Updated every edge. dbg_we = commit.
  - On commit: dbg_pc = pc_m; dbg_addr = {addr[31:2], 2'b00}; dbg_data = the merged word.
  - On no commit: dbg_pc, dbg_addr and dbg_data hold their values.
- Reset (asynchronous, takes effect immediately, held while asserted):
  - every memory word = 0;
  - dbg_we, dbg_pc, dbg_addr and dbg_data = 0;
  - no write occurs while reset=1, including a store that is in flight.
  - Combinational outputs follow their inputs during reset; with the memory cleared, rdata reads 0.
- Latency:
  - loads: 0 cycles (combinational);
  - stores: visible in memory 1 edge after the commit cycle;
  - debug trace: 1 edge.

Test Plan:
- Reset, then issue lw at 0x0, 0x10 and 0x3FFC -> rdata=0 for all; dbg_we=0.
- sw 0x12345678 @0x100, then lw @0x100 -> 0x12345678. Cycle after the store: dbg_we=1, dbg_addr=0x100, dbg_data=0x12345678, dbg_pc matches.
- Sub-word merges on word 0x100 (starting value 0x12345678):
  - sb 0xAB @0x101 -> dbg_data=0x1234AB78.
  - then sh 0xFFEE @0x102 -> word becomes 0xFFEEAB78.
- Loads from word 0x100 = 0xFFEEAB78:
  - lb @0x101 -> 0xFFFFFFAB; lbu -> 0x000000AB;
  - lh @0x102 -> 0xFFFFFFEE; lhu -> 0x0000FFEE.
- Address exceptions:
  - lw @0x102 -> exc_code=4;
  - sh @0x103 -> exc_code=5, memory unchanged, dbg_we=0;
  - sw @0x4000 with DEPTH=4096 -> exc_code=5, no write;
  - mem_op=110 load -> exc_code=4.
- Blocked and interrupted stores:
  - sw 0xDEAD @0x200 with flush=1 -> a later lw @0x200 returns the old value; dbg_we=0.
  - Assert reset mid-cycle while we=1 -> memory cleared immediately and the store is discarded.

Source files
------------

// File: rtl/mem_stage_dm.sv
// rtl/mem_stage_dm.sv - MEM-stage data memory: sized loads/stores, address exceptions, write trace
module mem_stage_dm #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  mem_op,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic        dbg_we,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_HU = 3'b001;
    localparam logic [2:0] OP_H  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b011;
    localparam logic [2:0] OP_B  = 3'b100;
    // Widened by one bit so DEPTH*4 cannot wrap for a full 4 GiB space.
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    logic [31:0] mem_q [DEPTH];
    logic        dbg_we_q;
    logic [31:0] dbg_pc_q, dbg_addr_q, dbg_data_q;

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   word;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [31:0]   merged;
    logic          misaligned, out_of_range, bad, load, commit;

    assign idx          = addr[AW+1:2];
    assign off          = addr[1:0];
    assign word         = mem_q[idx];
    assign half_sel     = addr[1] ? word[31:16] : word[15:0];
    assign byte_sel     = word[{off, 3'b000} +: 8];
    assign out_of_range = ({1'b0, addr} >= LIMIT);
    assign bad          = misaligned | out_of_range;
    assign load         = re & ~we;

    always_comb begin
        misaligned = 1'b0;
        case (mem_op)
            OP_W:        misaligned = (off != 2'b00);
            OP_HU, OP_H: misaligned = addr[0];
            OP_BU, OP_B: misaligned = 1'b0;
            default:     misaligned = 1'b1;
        endcase
    end

    always_comb begin
        exc_valid = 1'b0;
        exc_code  = 5'd0;
        if (we && bad) begin
            exc_valid = 1'b1;
            exc_code  = 5'd5;
        end else if (re && bad) begin
            exc_valid = 1'b1;
            exc_code  = 5'd4;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (load && !bad) begin
            case (mem_op)
                OP_W:    rdata = word;
                OP_HU:   rdata = {16'd0, half_sel};
                OP_H:    rdata = {{16{half_sel[15]}}, half_sel};
                OP_BU:   rdata = {24'd0, byte_sel};
                OP_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
                default: rdata = 32'd0;
            endcase
        end
    end

    // Read-modify-write: untouched lanes keep the current word contents.
    always_comb begin
        merged = word;
        case (mem_op)
            OP_W:        merged = wdata;
            OP_HU, OP_H: begin
                if (addr[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            OP_BU, OP_B: merged[{off, 3'b000} +: 8] = wdata[7:0];
            default:     merged = word;
        endcase
    end

    assign commit = we & ~exc_valid & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
            dbg_we_q   <= 1'b0;
            dbg_pc_q   <= 32'd0;
            dbg_addr_q <= 32'd0;
            dbg_data_q <= 32'd0;
        end else begin
            dbg_we_q <= commit;
            if (commit) begin
                mem_q[idx] <= merged;
                dbg_pc_q   <= pc_m;
                dbg_addr_q <= {addr[31:2], 2'b00};
                dbg_data_q <= merged;
            end
        end
    end

    assign dbg_we   = dbg_we_q;
    assign dbg_pc   = dbg_pc_q;
    assign dbg_addr = dbg_addr_q;
    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_mem_stage_dm.sv
// tb/tb_mem_stage_dm.sv - directed self-checking bench for mem_stage_dm
module tb_mem_stage_dm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_m = '0, addr = '0, wdata = '0;
    logic        re = 1'b0, we = 1'b0, flush = 1'b0;
    logic [2:0]  mem_op = '0;
    logic [31:0] rdata, dbg_pc, dbg_addr, dbg_data;
    logic        exc_valid, dbg_we;
    logic [4:0]  exc_code;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_dm #(.DEPTH(4096), .AW(12)) dut (
        .clk(clk), .reset(reset), .pc_m(pc_m), .addr(addr), .wdata(wdata),
        .re(re), .we(we), .mem_op(mem_op), .flush(flush), .rdata(rdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .dbg_we(dbg_we),
        .dbg_pc(dbg_pc), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic w, input logic r, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] p, input logic fl);
        we = w; re = r; mem_op = op; addr = a; wdata = d; pc_m = p; flush = fl;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        set_bus(1'b0, 1'b1, op, a, 32'd0, 32'd0, 1'b0);
        #1 check(tag, rdata, exp);
    endtask

    task automatic store(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p, input logic fl,
                         input logic [4:0] exp_code);
        @(negedge clk);
        set_bus(1'b1, 1'b0, op, a, d, p, fl);
        #1 check("st_exc_code", {27'd0, exc_code}, {27'd0, exp_code});
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_bus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("rst_dbg_we", {31'd0, dbg_we}, 32'd0);
        check("rst_dbg_pc", dbg_pc, 32'd0);
        check("rst_dbg_addr", dbg_addr, 32'd0);
        check("rst_dbg_data", dbg_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        load_chk("lw_0", 3'b000, 32'h0, 32'h0);
        load_chk("lw_10", 3'b000, 32'h10, 32'h0);
        load_chk("lw_3ffc", 3'b000, 32'h3FFC, 32'h0);
        check("lw_3ffc_noexc", {31'd0, exc_valid}, 32'd0);
        check("idle_dbg_we", {31'd0, dbg_we}, 32'd0);

        store(3'b000, 32'h100, 32'h12345678, 32'h0000_3000, 1'b0, 5'd0);
        check("sw_dbg_we", {31'd0, dbg_we}, 32'd1);
        check("sw_dbg_addr", dbg_addr, 32'h100);
        check("sw_dbg_data", dbg_data, 32'h12345678);
        check("sw_dbg_pc", dbg_pc, 32'h3000);
        load_chk("lw_100", 3'b000, 32'h100, 32'h12345678);
        @(posedge clk); #1;
        check("load_dbg_we", {31'd0, dbg_we}, 32'd0);
        check("load_dbg_hold", dbg_data, 32'h12345678);

        store(3'b011, 32'h101, 32'h000000AB, 32'h3004, 1'b0, 5'd0);
        check("sb_dbg_data", dbg_data, 32'h1234AB78);
        check("sb_dbg_addr", dbg_addr, 32'h100);
        store(3'b001, 32'h102, 32'h0000FFEE, 32'h3008, 1'b0, 5'd0);
        check("sh_dbg_data", dbg_data, 32'hFFEEAB78);
        check("sh_dbg_pc", dbg_pc, 32'h3008);

        load_chk("lb_101", 3'b100, 32'h101, 32'hFFFFFFAB);
        load_chk("lbu_101", 3'b011, 32'h101, 32'h000000AB);
        load_chk("lh_102", 3'b010, 32'h102, 32'hFFFFFFEE);
        load_chk("lhu_102", 3'b001, 32'h102, 32'h0000FFEE);
        load_chk("lb_100", 3'b100, 32'h100, 32'h00000078);
        load_chk("lb_103", 3'b100, 32'h103, 32'hFFFFFFFF);
        load_chk("lh_100", 3'b010, 32'h100, 32'hFFFFAB78);

        load_chk("lw_102_rdata", 3'b000, 32'h102, 32'h0);
        check("lw_102_code", {27'd0, exc_code}, 32'd4);
        check("lw_102_valid", {31'd0, exc_valid}, 32'd1);

        store(3'b001, 32'h103, 32'h00001111, 32'h300C, 1'b0, 5'd5);
        check("sh_mis_dbg_we", {31'd0, dbg_we}, 32'd0);
        load_chk("sh_mis_unchanged", 3'b000, 32'h100, 32'hFFEEAB78);

        store(3'b000, 32'h4000, 32'h55555555, 32'h3010, 1'b0, 5'd5);
        check("sw_oob_dbg_we", {31'd0, dbg_we}, 32'd0);
        load_chk("lw_4000_rdata", 3'b000, 32'h4000, 32'h0);
        check("lw_4000_code", {27'd0, exc_code}, 32'd4);
        store(3'b000, 32'h8000_0100, 32'h66666666, 32'h3014, 1'b0, 5'd5);
        load_chk("no_alias", 3'b000, 32'h100, 32'hFFEEAB78);

        load_chk("rsvd_op_rdata", 3'b110, 32'h100, 32'h0);
        check("rsvd_op_code", {27'd0, exc_code}, 32'd4);

        store(3'b000, 32'h200, 32'h0000CAFE, 32'h3018, 1'b0, 5'd0);
        check("sw_200_dbg_we", {31'd0, dbg_we}, 32'd1);
        store(3'b000, 32'h200, 32'h0000DEAD, 32'h301C, 1'b1, 5'd0);
        check("flush_dbg_we", {31'd0, dbg_we}, 32'd0);
        check("flush_dbg_pc_hold", dbg_pc, 32'h3018);
        load_chk("flush_old", 3'b000, 32'h200, 32'h0000CAFE);

        // Load and store together: acts as the store, no load data.
        @(negedge clk);
        set_bus(1'b1, 1'b1, 3'b000, 32'h204, 32'h0BADF00D, 32'h3020, 1'b0);
        #1 check("we_re_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        check("we_re_dbg_data", dbg_data, 32'h0BADF00D);
        load_chk("we_re_mem", 3'b000, 32'h204, 32'h0BADF00D);

        @(negedge clk);
        set_bus(1'b1, 1'b0, 3'b000, 32'h300, 32'h77777777, 32'h3024, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_dbg_we", {31'd0, dbg_we}, 32'd0);
        check("rst_mid_dbg_data", dbg_data, 32'h0);
        check("rst_mid_dbg_addr", dbg_addr, 32'h0);
        @(posedge clk); #1;
        set_bus(1'b0, 1'b1, 3'b000, 32'h100, 32'd0, 32'd0, 1'b0);
        #1 check("rst_mem_100", rdata, 32'h0);
        addr = 32'h300;
        #1 check("rst_mem_300", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        load_chk("post_rst_300", 3'b000, 32'h300, 32'h0);
        load_chk("post_rst_200", 3'b000, 32'h200, 32'h0);
        check("post_rst_dbg_we", {31'd0, dbg_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
